anim_scheduler: RTL and testbench

Frame-accurate scheduler for the LCD animation path. It selects which animation source feeds pixel data to the SPI LCD driver and which frame of it is shown, and it advances only at end-of-frame so no frame ever tears. A default idle animation loops continuously. A `go` request plays a chosen animation once, then the block returns to idle. Per-animation frame count and hold time sit in a small writable config table.

---
 rtl/anim_sched_pkg.sv | 25 ++
 rtl/anim_scheduler_if.sv | 27 ++
 rtl/anim_cfg_regfile.sv | 33 +++
 rtl/anim_scheduler.sv | 130 +++++++++++++
 tb/tb_anim_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/anim_sched_pkg.sv
// Shared sizing, state encoding and config-entry type for the LCD animation scheduler.
package anim_sched_pkg;

  localparam int NUM_ANIM = 4;
  localparam int FRAME_W  = 4;
  localparam int HOLD_W   = 4;
  localparam int ANIM_W   = $clog2(NUM_ANIM);

  typedef enum logic [1:0] {
    LOOP,
    ARMED,
    PLAY
  } state_t;

  typedef struct packed {
    logic [FRAME_W-1:0] frames;
    logic [HOLD_W-1:0]  hold;
  } cfg_entry_t;

  // Index of the final frame; a frame count of 0 behaves as a single frame.
  function automatic logic [FRAME_W-1:0] last_frame(input logic [FRAME_W-1:0] frames);
    return (frames == '0) ? '0 : frames - 1'b1;
  endfunction

endpackage

// File: rtl/anim_scheduler_if.sv
// Request, frame-timing, config and display-select signals of the animation scheduler.
interface anim_scheduler_if;
  import anim_sched_pkg::*;

  logic              go;
  logic [ANIM_W-1:0] anim_req;
  logic              frame_done;
  logic              cfg_we;
  logic [ANIM_W-1:0] cfg_addr;
  logic [FRAME_W-1:0] cfg_frames;
  logic [HOLD_W-1:0] cfg_hold;
  logic [ANIM_W-1:0] anim_sel;
  logic [FRAME_W-1:0] frame_idx;
  logic              busy;
  logic              anim_done;

  modport master (
    output go, anim_req, frame_done, cfg_we, cfg_addr, cfg_frames, cfg_hold,
    input  anim_sel, frame_idx, busy, anim_done
  );

  modport slave (
    input  go, anim_req, frame_done, cfg_we, cfg_addr, cfg_frames, cfg_hold,
    output anim_sel, frame_idx, busy, anim_done
  );

endinterface

// File: rtl/anim_cfg_regfile.sv
// Per-animation frame-count/hold table: one write port, one combinational read port.
module anim_cfg_regfile
  import anim_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ANIM_W-1:0]  waddr,
  input  logic [FRAME_W-1:0] wframes,
  input  logic [HOLD_W-1:0]  whold,
  input  logic [ANIM_W-1:0]  raddr,
  output cfg_entry_t         rdata
);

  cfg_entry_t mem [NUM_ANIM];

  // NOTE: this table is built from flops, not a RAM macro, so it takes an async
  // reset: every animation must come up as a valid 1-frame, no-hold entry.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ANIM; i++) begin
        mem[i] <= '{frames: FRAME_W'(1), hold: '0};
      end
    end else if (we && int'(waddr) < NUM_ANIM) begin
      mem[waddr] <= '{frames: wframes, hold: whold};
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/anim_scheduler.sv
// Frame-accurate animation scheduler: idle loop on id 0, one-shot play on go, switches only at frame_done.
// Optional preemption of an armed/playing request: define ANIM_SCHED_PREEMPT_EN.
module anim_scheduler
  import anim_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  anim_scheduler_if.slave bus
);

  state_t             state;
  logic               go_q;
  logic [ANIM_W-1:0]  pending;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [ANIM_W-1:0]  anim_sel;
  logic [FRAME_W-1:0] frame_idx;
  logic               busy;
  logic               anim_done;

  cfg_entry_t         cur;
  logic               go_rise;
  logic               preempt;
  logic [ANIM_W-1:0]  req_id;
  logic               hold_hit;
  logic               at_last;

  anim_cfg_regfile u_cfg (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.cfg_we),
    .waddr   (bus.cfg_addr),
    .wframes (bus.cfg_frames),
    .whold   (bus.cfg_hold),
    .raddr   (anim_sel),
    .rdata   (cur)
  );

  assign go_rise  = bus.go & ~go_q;
  assign req_id   = (int'(bus.anim_req) >= NUM_ANIM) ? '0 : bus.anim_req;
  assign hold_hit = (hold_cnt == cur.hold);
  // >= rather than == so a shrunk frame count ends the sequence at the next advance.
  assign at_last  = (frame_idx >= last_frame(cur.frames));

`ifdef ANIM_SCHED_PREEMPT_EN
  assign preempt = go_rise;
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOOP;
      go_q      <= 1'b0;
      pending   <= '0;
      hold_cnt  <= '0;
      anim_sel  <= '0;
      frame_idx <= '0;
      busy      <= 1'b0;
      anim_done <= 1'b0;
    end else begin
      go_q      <= bus.go;
      anim_done <= 1'b0;

      unique case (state)
        LOOP: begin
          if (bus.frame_done) begin
            if (!hold_hit) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              hold_cnt  <= '0;
              frame_idx <= at_last ? '0 : frame_idx + 1'b1;
            end
          end
          // A request arriving on a boundary waits for the following one.
          if (go_rise) begin
            pending <= req_id;
            busy    <= 1'b1;
            state   <= ARMED;
          end
        end

        ARMED: begin
          if (preempt) begin
            pending <= req_id;
          end
          if (bus.frame_done) begin
            anim_sel  <= pending;
            frame_idx <= '0;
            hold_cnt  <= '0;
            state     <= PLAY;
          end
        end

        PLAY: begin
          if (bus.frame_done) begin
            if (!hold_hit) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              hold_cnt <= '0;
              if (!at_last) begin
                frame_idx <= frame_idx + 1'b1;
              end else if (preempt) begin
                frame_idx <= '0;
              end else begin
                anim_done <= 1'b1;
                anim_sel  <= '0;
                frame_idx <= '0;
                busy      <= 1'b0;
                state     <= LOOP;
              end
            end
          end
          // Preempted animation keeps showing until the next boundary, with no anim_done.
          if (preempt) begin
            pending <= req_id;
            state   <= ARMED;
          end
        end

        default: state <= LOOP;
      endcase
    end
  end

  assign bus.anim_sel  = anim_sel;
  assign bus.frame_idx = frame_idx;
  assign bus.busy      = busy;
  assign bus.anim_done = anim_done;

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed, table-driven bench for anim_scheduler: one vector per clock, outputs checked 1 ns after the edge.
module tb_anim_scheduler;
  import anim_sched_pkg::*;

  typedef struct packed {
    logic               go;
    logic [ANIM_W-1:0]  req;
    logic               fd;
    logic               we;
    logic [ANIM_W-1:0]  addr;
    logic [FRAME_W-1:0] fr;
    logic [HOLD_W-1:0]  hd;
    logic [ANIM_W-1:0]  sel;
    logic [FRAME_W-1:0] idx;
    logic               busy;
    logic               done;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_no  = 0;
  vec_t vecs[$];

  anim_scheduler_if bus ();

  anim_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outs(input string tag, input int sel, input int idx, input int busy, input int done);
    check({tag, "_sel"},  int'(bus.anim_sel),  sel);
    check({tag, "_idx"},  int'(bus.frame_idx), idx);
    check({tag, "_busy"}, int'(bus.busy),      busy);
    check({tag, "_done"}, int'(bus.anim_done), done);
  endtask

  function automatic vec_t mk(input int go, input int req, input int fd, input int we,
                              input int addr, input int fr, input int hd,
                              input int sel, input int idx, input int busy, input int done);
    vec_t v;
    v.go   = go[0];
    v.req  = ANIM_W'(req);
    v.fd   = fd[0];
    v.we   = we[0];
    v.addr = ANIM_W'(addr);
    v.fr   = FRAME_W'(fr);
    v.hd   = HOLD_W'(hd);
    v.sel  = ANIM_W'(sel);
    v.idx  = FRAME_W'(idx);
    v.busy = busy[0];
    v.done = done[0];
    return v;
  endfunction

  // Drive one cycle of inputs, then compare the registered outputs after the edge.
  task automatic apply(input vec_t v);
    bus.go         = v.go;
    bus.anim_req   = v.req;
    bus.frame_done = v.fd;
    bus.cfg_we     = v.we;
    bus.cfg_addr   = v.addr;
    bus.cfg_frames = v.fr;
    bus.cfg_hold   = v.hd;
    @(posedge clk);
    #1;
    check_outs($sformatf("v%0d", vec_no), int'(v.sel), int'(v.idx), int'(v.busy), int'(v.done));
    vec_no++;
  endtask

  // Shorthand for vectors without a config write.
  function automatic vec_t st(input int go, input int req, input int fd,
                              input int sel, input int idx, input int busy, input int done);
    return mk(go, req, fd, 0, 0, 0, 0, sel, idx, busy, done);
  endfunction

  initial begin
    int seq_idle [8];
    seq_idle = '{0, 1, 1, 2, 2, 0, 0, 1};

    rst_n          = 1'b0;
    bus.go         = 1'b0;
    bus.anim_req   = '0;
    bus.frame_done = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_frames = '0;
    bus.cfg_hold   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Default config: idle loop is a single frame and never moves.
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(st(0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(st(0, 0, 0, 0, 0, 0, 0));
    end

    // Idle frames=3 hold=1: frame changes every second pulse.
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(st(0, 0, 1, 0, seq_idle[i], 0, 0));
      vecs.push_back(st(0, 0, 0, 0, seq_idle[i], 0, 0));
    end

    // Same-cycle write uses the old entry; the shrunk count then wraps from frame 2.
    vecs.push_back(st(0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 2, 0, 0));
    vecs.push_back(st(0, 0, 1, 0, 0, 0, 0));

    // Anim 2: frames=4 hold=0; anim 3: frames=2 hold=0.
    vecs.push_back(mk(0, 0, 0, 1, 2, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0));

    // One-shot play of anim 2.
    vecs.push_back(st(1, 2, 0, 0, 0, 1, 0));
    vecs.push_back(st(1, 2, 0, 0, 0, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 0, 1, 0));
    vecs.push_back(st(1, 2, 0, 2, 0, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 1, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 2, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 3, 1, 0));
    vecs.push_back(st(1, 2, 1, 0, 0, 0, 1));
    vecs.push_back(st(0, 0, 0, 0, 0, 0, 0));

    // go rise on a boundary: arms now, switches at the following boundary.
    vecs.push_back(st(1, 2, 1, 0, 0, 1, 0));
    vecs.push_back(st(1, 2, 0, 0, 0, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 0, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 1, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 2, 1, 0));
    vecs.push_back(st(1, 2, 1, 2, 3, 1, 0));
    vecs.push_back(st(1, 2, 1, 0, 0, 0, 1));
    vecs.push_back(st(0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // go rise for anim 3 while anim 2 is playing frame 1.
    apply(st(1, 2, 0, 0, 0, 1, 0));
    apply(st(1, 2, 1, 2, 0, 1, 0));
    apply(st(1, 2, 1, 2, 1, 1, 0));
    apply(st(0, 2, 0, 2, 1, 1, 0));
    apply(st(1, 3, 0, 2, 1, 1, 0));
`ifdef ANIM_SCHED_PREEMPT_EN
    apply(st(1, 3, 1, 3, 0, 1, 0));
    apply(st(1, 3, 1, 3, 1, 1, 0));
    apply(st(1, 3, 1, 0, 0, 0, 1));
`else
    apply(st(1, 3, 1, 2, 2, 1, 0));
    apply(st(1, 3, 1, 2, 3, 1, 0));
    apply(st(1, 3, 1, 0, 0, 0, 1));
`endif
    apply(st(0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of playing anim 2 at frame 2.
    apply(st(1, 2, 0, 0, 0, 1, 0));
    apply(st(1, 2, 1, 2, 0, 1, 0));
    apply(st(1, 2, 1, 2, 1, 1, 0));
    apply(st(1, 2, 1, 2, 2, 1, 0));
    bus.go         = 1'b0;
    bus.frame_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("midreset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outs("postreset", 0, 0, 0, 0);

    // Config back to defaults: anim 2 is now one frame, so it finishes on its first advance.
    apply(st(0, 0, 1, 0, 0, 0, 0));
    apply(st(1, 2, 0, 0, 0, 1, 0));
    apply(st(1, 2, 1, 2, 0, 1, 0));
    apply(st(1, 2, 1, 0, 0, 0, 1));
    apply(st(0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
